// File: rtl/lock_code_sender.sv
// Replays a programmed press code into a two-button lock, then watches unlock
// for a bounded window and reports pass/fail.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_PRESS | one-cycle button press of CODE[idx_q]
//   S_GAP   | idle cycles between presses
//   S_CHECK | watching unlock, timeout down-counter running
//   S_DONE  | one-cycle completion pulse
module lock_code_sender #(
    parameter int                  CODE_LEN = 5,
    parameter logic [CODE_LEN-1:0] CODE     = 5'b11010,
    parameter int                  GAP      = 2,
    parameter int                  TIMEOUT  = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic abort_i,
    input  logic unlock_i,
    output logic btn_0_o,
    output logic btn_1_o,
    output logic busy_o,
    output logic done_o,
    output logic pass_o
);

    localparam int IDX_W = ($clog2(CODE_LEN) > 1) ? $clog2(CODE_LEN) : 1;
    localparam int GAP_W = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;
    localparam int TO_W  = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               pass_q, pass_d;
    logic               cur_bit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            to_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        to_d    = to_q;
        pass_d  = pass_q;
        if (abort_i) begin
            state_d = S_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        idx_d   = IDX_W'(CODE_LEN - 1);
                        state_d = S_PRESS;
                    end
                end
                S_PRESS: begin
                    if (idx_q == '0) begin
                        to_d    = TO_W'(TIMEOUT);
                        state_d = S_CHECK;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                        if (GAP == 0) begin
                            state_d = S_PRESS;
                        end else begin
                            gap_d   = GAP_W'(GAP);
                            state_d = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q <= GAP_W'(1)) begin
                        state_d = S_PRESS;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                S_CHECK: begin
                    // unlock beats timeout, so unlock on the last window cycle passes
                    if (unlock_i) begin
                        pass_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (to_q <= TO_W'(1)) begin
                        pass_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        to_d = to_q - TO_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign cur_bit = CODE[idx_q];
    assign btn_1_o = (state_q == S_PRESS) &  cur_bit;
    assign btn_0_o = (state_q == S_PRESS) & ~cur_bit;
    assign busy_o  = (state_q == S_PRESS) | (state_q == S_GAP) | (state_q == S_CHECK);
    assign done_o  = (state_q == S_DONE);
    assign pass_o  = pass_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: three instances (default, wrong code, no gap),
// each driving a small shift-register lock model that opens on 11010.
module tb_lock_code_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start [3];
    logic abort [3];
    logic force_unl [3];
    logic unl [3];
    logic lk_unl [3];
    logic [3:0] lk_sh [3];
    logic btn0 [3];
    logic btn1 [3];
    logic busy [3];
    logic done [3];
    logic pass [3];

    int n_assert = 0;
    int n_fail = 0;

    bit exp_press [3][$];
    bit exp_res [3][$];

    lock_code_sender dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .abort_i(abort[0]),
        .unlock_i(unl[0]), .btn_0_o(btn0[0]), .btn_1_o(btn1[0]), .busy_o(busy[0]),
        .done_o(done[0]), .pass_o(pass[0]));

    lock_code_sender #(.CODE(5'b11011)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .abort_i(abort[1]),
        .unlock_i(unl[1]), .btn_0_o(btn0[1]), .btn_1_o(btn1[1]), .busy_o(busy[1]),
        .done_o(done[1]), .pass_o(pass[1]));

    lock_code_sender #(.GAP(0)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .abort_i(abort[2]),
        .unlock_i(unl[2]), .btn_0_o(btn0[2]), .btn_1_o(btn1[2]), .busy_o(busy[2]),
        .done_o(done[2]), .pass_o(pass[2]));

    for (genvar g = 0; g < 3; g++) begin : g_unl
        assign unl[g] = lk_unl[g] | force_unl[g];
    end

    // Lock model: opens for one cycle after a press completes the sequence 11010
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                lk_sh[i]  <= 4'b0;
                lk_unl[i] <= 1'b0;
            end else if (btn0[i] || btn1[i]) begin
                lk_sh[i]  <= {lk_sh[i][2:0], btn1[i]};
                lk_unl[i] <= ({lk_sh[i], btn1[i]} == 5'b11010);
            end else begin
                lk_unl[i] <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pops expected press values and results as the DUTs produce them
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                bit e;
                if (btn0[i] || btn1[i]) begin
                    chk($sformatf("btn_overlap[%0d]", i), btn0[i] & btn1[i], 0);
                    if (exp_press[i].size() == 0) begin
                        chk($sformatf("press_unexpected[%0d]", i), 1, 0);
                    end else begin
                        e = exp_press[i].pop_front();
                        chk($sformatf("press_val[%0d]", i), btn1[i], e);
                    end
                end
                if (done[i]) begin
                    if (exp_res[i].size() == 0) begin
                        chk($sformatf("done_unexpected[%0d]", i), 1, 0);
                    end else begin
                        e = exp_res[i].pop_front();
                        chk($sformatf("result[%0d]", i), pass[i], e);
                    end
                end
            end
        end
    end

    // Called at a negedge (cycle 0); start is sampled at the following edge.
    task automatic run_seq(input int i, input int gap, input logic [4:0] code,
                           input int chk_len, input bit exp_pass,
                           input int sp_c, input int uf_c);
        int len;
        int dn;
        int pc;
        int k;
        bit is_press;
        bit eb;
        len = 5 + 4 * gap;
        dn  = len + chk_len + 1;
        for (int j = 0; j < 5; j++) exp_press[i].push_back(code[4 - j]);
        exp_res[i].push_back(exp_pass);
        start[i] = 1'b1;
        for (int c = 1; c <= dn; c++) begin
            @(negedge clk);
            start[i]     = (c == sp_c);
            force_unl[i] = (c == uf_c);
            pc       = c - 1;
            is_press = (c <= len) && ((pc % (gap + 1)) == 0);
            k        = pc / (gap + 1);
            eb       = is_press ? code[4 - k] : 1'b0;
            chk($sformatf("btn1[%0d] c%0d", i, c), btn1[i], is_press & eb);
            chk($sformatf("btn0[%0d] c%0d", i, c), btn0[i], is_press & ~eb);
            chk($sformatf("busy[%0d] c%0d", i, c), busy[i], c <= len + chk_len);
            chk($sformatf("done[%0d] c%0d", i, c), done[i], c == dn);
            if (c == dn) chk($sformatf("pass_at_done[%0d]", i), pass[i], exp_pass);
        end
        @(negedge clk);
        start[i]     = 1'b0;
        force_unl[i] = 1'b0;
        chk($sformatf("idle_busy[%0d]", i), busy[i], 0);
        chk($sformatf("idle_done[%0d]", i), done[i], 0);
        chk($sformatf("pass_hold[%0d]", i), pass[i], exp_pass);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            force_unl[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_outs[%0d]", i),
                {btn0[i], btn1[i], busy[i], done[i], pass[i]}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal unlock, wrong code, back-to-back presses
        run_seq(0, 2, 5'b11010, 1, 1'b1, 0, 0);
        run_seq(1, 2, 5'b11011, 4, 1'b0, 0, 0);
        run_seq(2, 0, 5'b11010, 1, 1'b1, 0, 0);

        // Abort during the GAP in cycle 8; presses at 1,4,7 still expected
        exp_press[0].push_back(1'b1);
        exp_press[0].push_back(1'b1);
        exp_press[0].push_back(1'b0);
        start[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
            abort[0] = (c == 8);
        end
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_btn", {btn0[0], btn1[0]}, 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_done", done[0], 0);
        chk("abort_pass", pass[0], 0);
        chk("abort_flush", exp_press[0].size(), 0);
        @(negedge clk);
        run_seq(0, 2, 5'b11010, 1, 1'b1, 0, 0);

        // abort and start together in IDLE: abort wins
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk("abort_start_busy", busy[0], 0);
        chk("abort_start_btn", {btn0[0], btn1[0]}, 0);
        chk("abort_start_pass", pass[0], 0);
        @(negedge clk);

        // Ignored start during GAP/CHECK, stray unlock during GAP, unlock on last CHECK cycle
        run_seq(0, 2, 5'b11010, 1, 1'b1, 2, 2);
        run_seq(1, 2, 5'b11011, 4, 1'b0, 15, 5);
        run_seq(1, 2, 5'b11011, 4, 1'b1, 0, 17);

        // Asynchronous reset in the middle of the second press (cycle 4)
        for (int j = 0; j < 5; j++) exp_press[0].push_back(j == 2 || j == 4 ? 1'b0 : 1'b1);
        exp_res[0].push_back(1'b1);
        start[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        chk("pre_rst_btn1", btn1[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_rst_outs[%0d]", i),
                {btn0[i], btn1[i], busy[i], done[i], pass[i]}, 0);
            exp_press[i].delete();
            exp_res[i].delete();
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy[0], 0);
        run_seq(0, 2, 5'b11010, 1, 1'b1, 0, 0);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("press_left[%0d]", i), exp_press[i].size(), 0);
            chk($sformatf("result_left[%0d]", i), exp_res[i].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
